flap_lift: RTL and testbench



---
 rtl/flap_lift.sv | 117 +++++++++++
 tb/tb_flap_lift.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/flap_lift.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : flap_lift                                                  |
// | Description : Turns one-cycle flap pulses into the bird's vertical row.  |
// |               A flap starts a timed lift; gravity pulls the bird down    |
// |               one row per motion step; falling past row 0 latches crash. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module flap_lift #(
  parameter int ROWS       = 8,
  parameter int TICK_DIV   = 25,
  parameter int RISE_STEPS = 2,
  parameter int START_ROW  = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    flap,
  input  logic                    enable,
  output logic [$clog2(ROWS)-1:0] row,
  output logic [ROWS-1:0]         row_onehot,
  output logic                    rising,
  output logic                    crashed
);

  localparam int c_ROW_W  = $clog2(ROWS);
  localparam int c_PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_RISE_W = $clog2(RISE_STEPS + 1);

  localparam logic [c_ROW_W-1:0]  c_TOP       = c_ROW_W'(ROWS - 1);
  localparam logic [c_ROW_W-1:0]  c_START     = c_ROW_W'(START_ROW);
  localparam logic [c_PRE_W-1:0]  c_PRE_LAST  = c_PRE_W'(TICK_DIV - 1);
  localparam logic [c_RISE_W-1:0] c_RISE_LOAD = c_RISE_W'(RISE_STEPS);
  localparam logic [c_RISE_W-1:0] c_RISE_ONE  = c_RISE_W'(1);

  typedef enum logic [1:0] {
    S_FALL    = 2'd0,
    S_RISE    = 2'd1,
    S_CRASHED = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_PRE_W-1:0]  r_prescale;
  logic [c_RISE_W-1:0] r_rise_left;

  logic                w_active;
  logic                w_step;
  logic [c_ROW_W-1:0]  w_row_up;
  logic [c_ROW_W-1:0]  w_row_dn;

  function automatic logic [ROWS-1:0] f_onehot(input logic [c_ROW_W-1:0] r);
    f_onehot = ROWS'(1) << r;
  endfunction

  // Motion-step strobe and the candidate rows one step up (saturating) and down.
  always_comb begin
    w_active = enable && (r_state != S_CRASHED);
    w_step   = enable && (r_prescale == c_PRE_LAST);
    w_row_up = (row == c_TOP) ? row : row + c_ROW_W'(1);
    w_row_dn = row - c_ROW_W'(1);
  end

  // Prescaler, lift/fall/crash state machine and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= S_FALL;
      r_prescale  <= '0;
      r_rise_left <= '0;
      row         <= c_START;
      row_onehot  <= f_onehot(c_START);
      rising      <= 1'b0;
      crashed     <= 1'b0;
    end else if (w_active) begin
      // The prescaler wraps on a step even when a flap takes priority.
      r_prescale <= w_step ? '0 : r_prescale + c_PRE_W'(1);
      case (r_state)
        S_FALL: begin
          if (flap) begin
            r_state     <= S_RISE;
            r_rise_left <= c_RISE_LOAD;
            rising      <= 1'b1;
          end else if (w_step) begin
            if (row == '0) begin
              // Falling out of the bottom row is the crash; row stays 0.
              r_state <= S_CRASHED;
              crashed <= 1'b1;
            end else begin
              row        <= w_row_dn;
              row_onehot <= f_onehot(w_row_dn);
            end
          end
        end
        S_RISE: begin
          if (flap) begin
            // Retrigger: a new flap restarts the full lift.
            r_rise_left <= c_RISE_LOAD;
          end else if (w_step) begin
            row         <= w_row_up;
            row_onehot  <= f_onehot(w_row_up);
            r_rise_left <= r_rise_left - c_RISE_W'(1);
            if (r_rise_left == c_RISE_ONE) begin
              r_state <= S_FALL;
              rising  <= 1'b0;
            end
          end
        end
        default: begin
          // Unused encoding: recover into normal falling.
          r_state <= S_FALL;
          rising  <= 1'b0;
          crashed <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flap_lift.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_flap_lift                                               |
// | Description : Directed and randomized bench for flap_lift, compared      |
// |               each cycle against a behavioural model of the bird.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_flap_lift;

  localparam int NR = 8;
  localparam int TD = 4;
  localparam int RS = 2;

  localparam int M_FALL  = 0;
  localparam int M_RISE  = 1;
  localparam int M_CRASH = 2;

  logic       Clock  = 1'b0;
  logic       Reset  = 1'b1;
  logic       flap   = 1'b0;
  logic       enable = 1'b0;

  logic [2:0] row_a, row_b;
  logic [7:0] oh_a, oh_b;
  logic       rise_a, rise_b, cr_a, cr_b;

  int n_checks = 0;
  int n_err    = 0;

  // Model of each instance: row, mode, cycles into current step, lift steps left.
  int m_row[2];
  int m_mode[2];
  int m_cnt[2];
  int m_left[2];

  always #5 Clock = ~Clock;

  flap_lift #(.ROWS(NR), .TICK_DIV(TD), .RISE_STEPS(RS), .START_ROW(4)) dut_a (
    .Clock(Clock), .Reset(Reset), .flap(flap), .enable(enable),
    .row(row_a), .row_onehot(oh_a), .rising(rise_a), .crashed(cr_a)
  );

  flap_lift #(.ROWS(NR), .TICK_DIV(TD), .RISE_STEPS(RS), .START_ROW(6)) dut_b (
    .Clock(Clock), .Reset(Reset), .flap(flap), .enable(enable),
    .row(row_b), .row_onehot(oh_b), .rising(rise_b), .crashed(cr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int k, input logic r, input logic f, input logic e);
    bit step;
    if (r) begin
      m_row[k]  = (k == 0) ? 4 : 6;
      m_mode[k] = M_FALL;
      m_cnt[k]  = 0;
      m_left[k] = 0;
    end else if (e && m_mode[k] != M_CRASH) begin
      step     = (m_cnt[k] == TD - 1);
      m_cnt[k] = (m_cnt[k] + 1) % TD;
      if (f) begin
        m_mode[k] = M_RISE;
        m_left[k] = RS;
      end else if (step && m_mode[k] == M_FALL) begin
        if (m_row[k] == 0) m_mode[k] = M_CRASH;
        else m_row[k] = m_row[k] - 1;
      end else if (step) begin
        if (m_row[k] < NR - 1) m_row[k] = m_row[k] + 1;
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 0) m_mode[k] = M_FALL;
      end
    end
  endtask

  task automatic compare();
    chk("row_a",      row_a,  m_row[0]);
    chk("onehot_a",   oh_a,   1 << m_row[0]);
    chk("rising_a",   rise_a, m_mode[0] == M_RISE);
    chk("crashed_a",  cr_a,   m_mode[0] == M_CRASH);
    chk("row_b",      row_b,  m_row[1]);
    chk("onehot_b",   oh_b,   1 << m_row[1]);
    chk("rising_b",   rise_b, m_mode[1] == M_RISE);
    chk("crashed_b",  cr_b,   m_mode[1] == M_CRASH);
  endtask

  // One clock cycle: drive, clock the model alongside the DUT, then compare.
  task automatic tick(input logic r, input logic f, input logic e);
    Reset  = r;
    flap   = f;
    enable = e;
    @(posedge Clock);
    model(0, r, f, e);
    model(1, r, f, e);
    #1;
    compare();
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Fall from start row to crash, then crash holds.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("rst_row",      row_a,  4);
    chk("rst_onehot",   oh_a,   8'h10);
    chk("rst_rising",   rise_a, 0);
    chk("rst_crashed",  cr_a,   0);
    chk("rst_row_b",    row_b,  6);
    quiet(4);
    chk("s1_row_c4",    row_a,  3);
    quiet(8);
    chk("s1_row_c12",   row_a,  1);
    quiet(12);
    chk("s1_row_c24",   row_a,  0);
    chk("s1_crash_c24", cr_a,   1);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'($urandom_range(0, 1)), 1'b1);
    chk("s1_hold_row",  row_a,  0);
    chk("s1_hold_crash", cr_a,  1);

    // Single flap: two rows up, then fall resumes.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    chk("s2_rising_c1", rise_a, 1);
    quiet(3);
    chk("s2_row_c4",    row_a,  5);
    chk("s2_rise_c4",   rise_a, 1);
    quiet(4);
    chk("s2_row_c8",    row_a,  6);
    chk("s2_rise_c8",   rise_a, 0);
    quiet(4);
    chk("s2_row_c12",   row_a,  5);

    // Repeated flaps saturate at the top row without crashing.
    tick(1'b1, 1'b0, 1'b0);
    for (int f = 0; f < 6; f++) begin
      tick(1'b0, 1'b1, 1'b1);
      quiet(3);
    end
    chk("s3_row_b",     row_b,  7);
    chk("s3_crash_b",   cr_b,   0);
    chk("s3_row_a",     row_a,  7);

    // Flap on a step cycle while falling at row 3.
    tick(1'b1, 1'b0, 1'b0);
    quiet(4);
    chk("s4_row_c4",    row_a,  3);
    quiet(3);
    tick(1'b0, 1'b1, 1'b1);
    chk("s4_row_c8",    row_a,  3);
    chk("s4_rise_c8",   rise_a, 1);
    quiet(4);
    chk("s4_row_c12",   row_a,  4);
    quiet(4);
    chk("s4_row_c16",   row_a,  5);
    chk("s4_rise_c16",  rise_a, 0);

    // Crash absorbs flaps; reset recovers and restarts the prescaler.
    tick(1'b1, 1'b0, 1'b0);
    quiet(24);
    chk("s5_crash",     cr_a,   1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b0, 1'b1);
    end
    chk("s5_row",       row_a,  0);
    chk("s5_crash_hold", cr_a,  1);
    chk("s5_rise",      rise_a, 0);
    tick(1'b1, 1'b1, 1'b1);
    chk("s5_rst_row",   row_a,  4);
    chk("s5_rst_crash", cr_a,   0);
    quiet(3);
    chk("s5_row_c3",    row_a,  4);
    quiet(1);
    chk("s5_row_c4",    row_a,  3);

    // Freeze mid-lift; the flap during freeze is dropped.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    quiet(3);
    chk("s6_row_c4",    row_a,  5);
    quiet(2);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'(i == 4), 1'b0);
    chk("s6_frz_row",   row_a,  5);
    chk("s6_frz_rise",  rise_a, 1);
    quiet(1);
    chk("s6_re_row",    row_a,  5);
    quiet(1);
    chk("s6_step_row",  row_a,  6);
    chk("s6_step_rise", rise_a, 0);

    // Randomized play with varying flap rates.
    tick(1'b1, 1'b0, 1'b0);
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 500; i++) begin
        tick(1'($urandom_range(0, 199) == 0),
             1'($urandom_range(0, 2 + blk) == 0),
             1'($urandom_range(0, 7) != 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
